// File: rtl/fpg8_alu_pkg.sv
// Shared definitions for the Z-stage ALU: opcodes, flag bit positions and FSM states.
package fpg8_alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;
    localparam logic [2:0] ALU_PASS = 3'd6;
    localparam logic [2:0] ALU_MULU = 3'd7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_MUL  = 1'b1;

    typedef enum logic {
        IDLE = STATE_IDLE,
        MUL  = STATE_MUL
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU datapath (ADD..PASS) producing result, carry and overflow.
module alu_comb
    import fpg8_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // SUB reuses the adder as A + ~B + 1, so C=1 means no borrow.
    assign is_sub = (op == ALU_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOT:  result = ~a;
            ALU_PASS: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_z_stage.sv
// ALU execution stage: single-cycle ops load Z directly; MULU runs a 16-step shift-add sequence.
module alu_z_stage
    import fpg8_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] from_bus,
    input  logic [WIDTH-1:0] Y_shifted,
    input  logic [2:0]       alu_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z_out,
    output logic [3:0]       flags
);

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mult;
    logic [3:0]         cnt;

    logic [WIDTH-1:0]   comb_result;
    logic               comb_carry;
    logic               comb_overflow;

    logic               issue_single;
    logic               issue_mul;
    logic               mul_last;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_alu_comb (
        .a        (from_bus),
        .b        (Y_shifted),
        .op       (alu_op),
        .result   (comb_result),
        .carry    (comb_carry),
        .overflow (comb_overflow)
    );

    always_comb begin
        issue_single = (state == IDLE) && start && (alu_op != ALU_MULU);
        issue_mul    = (state == IDLE) && start && (alu_op == ALU_MULU);
        mul_last     = (state == MUL) && (cnt == 4'd15);
        acc_next     = mult[0] ? (acc + mcand) : acc;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue_mul) state_next = MUL;
            MUL:     if (mul_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Reset discards any in-flight multiply so no partial product ever reaches Z.
    always_ff @(posedge clk) begin
        if (reset) begin
            Z_out <= '0;
            flags <= '0;
            done  <= 1'b0;
            mcand <= '0;
            acc   <= '0;
            mult  <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (issue_single) begin
                Z_out         <= comb_result;
                flags[FLAG_N] <= comb_result[WIDTH-1];
                flags[FLAG_Z] <= (comb_result == '0);
                flags[FLAG_C] <= comb_carry;
                flags[FLAG_V] <= comb_overflow;
                done          <= 1'b1;
            end
            if (issue_mul) begin
                mcand <= {{WIDTH{1'b0}}, from_bus};
                mult  <= Y_shifted;
                acc   <= '0;
                cnt   <= '0;
            end
            if (state == MUL) begin
                acc   <= acc_next;
                mcand <= mcand << 1;
                mult  <= mult >> 1;
                cnt   <= cnt + 4'd1;
                if (mul_last) begin
                    Z_out         <= acc_next[WIDTH-1:0];
                    flags[FLAG_N] <= acc_next[WIDTH-1];
                    flags[FLAG_Z] <= (acc_next[WIDTH-1:0] == '0);
                    flags[FLAG_C] <= 1'b0;
                    flags[FLAG_V] <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                    done          <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == MUL);

endmodule

// File: tb/tb_alu_z_stage.sv
// Randomized self-checking bench for alu_z_stage against an arithmetic reference model.
module tb_alu_z_stage;

    logic        clk;
    logic        reset;
    logic [15:0] from_bus;
    logic [15:0] Y_shifted;
    logic [2:0]  alu_op;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] Z_out;
    logic [3:0]  flags;

    int checks;
    int failures;

    alu_z_stage #(
        .WIDTH(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .from_bus  (from_bus),
        .Y_shifted (Y_shifted),
        .alu_op    (alu_op),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .Z_out     (Z_out),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {flags[3:0], z[15:0]} from plain integer arithmetic on the operands.
    function automatic logic [19:0] ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int          ua, ub, sa, sb, r_int, s_int;
        longint      prod;
        logic [15:0] r;
        logic        c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r = 16'h0;
        case (op)
            3'd0: begin
                r_int = ua + ub;
                r     = r_int[15:0];
                c     = (r_int > 65535);
                s_int = sa + sb;
                v     = (s_int > 32767) || (s_int < -32768);
            end
            3'd1: begin
                r_int = ua - ub;
                r     = r_int[15:0];
                c     = (ua >= ub);
                s_int = sa - sb;
                v     = (s_int > 32767) || (s_int < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = b;
            default: begin
                prod = longint'(ua) * longint'(ub);
                r    = prod[15:0];
                v    = ((prod >> 16) != 0);
            end
        endcase
        return {r[15], (r == 16'h0), c, v, r};
    endfunction

    // Single-cycle op: issue at one edge, expect result and done right after it.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] e;
        e = ref_model(op, a, b);
        from_bus  = a;
        Y_shifted = b;
        alu_op    = op;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        from_bus  = 16'($urandom);
        Y_shifted = 16'($urandom);
        checkOutput("single_done", 32'(done), 32'd1);
        checkOutput("single_busy", 32'(busy), 32'd0);
        checkOutput("single_z", 32'(Z_out), 32'(e[15:0]));
        checkOutput("single_flags", 32'(flags), 32'(e[19:16]));
    endtask

    // MULU: expects busy for edges 1..15 after issue, done exactly at the 16th edge.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit with_noise);
        logic [19:0] e;
        e = ref_model(3'd7, a, b);
        from_bus  = a;
        Y_shifted = b;
        alu_op    = 3'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        from_bus  = 16'($urandom);
        Y_shifted = 16'($urandom);
        alu_op    = 3'($urandom_range(0, 6));
        checkOutput("mul_busy_start", 32'(busy), 32'd1);
        checkOutput("mul_done_start", 32'(done), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            start = with_noise && (i == 3 || i == 9);
            tick();
            start = 1'b0;
            if (i < 16) begin
                checkOutput("mul_busy", 32'(busy), 32'd1);
                checkOutput("mul_done_early", 32'(done), 32'd0);
            end else begin
                checkOutput("mul_done", 32'(done), 32'd1);
                checkOutput("mul_busy_end", 32'(busy), 32'd0);
                checkOutput("mul_z", 32'(Z_out), 32'(e[15:0]));
                checkOutput("mul_flags", 32'(flags), 32'(e[19:16]));
            end
        end
    endtask

    // One cycle with no request: done drops and Z/flags hold.
    task automatic idle_cycle();
        logic [15:0] z_before;
        logic [3:0]  f_before;
        z_before = Z_out;
        f_before = flags;
        start    = 1'b0;
        tick();
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_z_hold", 32'(Z_out), 32'(z_before));
        checkOutput("idle_flags_hold", 32'(flags), 32'(f_before));
    endtask

    initial begin
        logic [2:0]  op;
        logic [15:0] a, b;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        from_bus  = 16'h0;
        Y_shifted = 16'h0;
        alu_op    = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_z", 32'(Z_out), 32'h0);
        checkOutput("reset_flags", 32'(flags), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        tick();

        applyStimulus(3'd0, 16'h7FFF, 16'h0001);
        checkOutput("add_ovf_z", 32'(Z_out), 32'h8000);
        checkOutput("add_ovf_flags", 32'(flags), 32'b1001);
        idle_cycle();

        applyStimulus(3'd1, 16'h0005, 16'h0005);
        checkOutput("sub_zero_z", 32'(Z_out), 32'h0000);
        checkOutput("sub_zero_flags", 32'(flags), 32'b0110);
        idle_cycle();

        applyStimulus(3'd1, 16'h0000, 16'h0001);
        checkOutput("sub_borrow_z", 32'(Z_out), 32'hFFFF);
        checkOutput("sub_borrow_flags", 32'(flags), 32'b1000);
        idle_cycle();

        run_mul(16'h0003, 16'h0007, 1'b0);
        checkOutput("mul_small_z", 32'(Z_out), 32'h0015);
        checkOutput("mul_small_flags", 32'(flags), 32'b0000);
        idle_cycle();

        run_mul(16'h0100, 16'h0100, 1'b0);
        checkOutput("mul_wrap_z", 32'(Z_out), 32'h0000);
        checkOutput("mul_wrap_flags", 32'(flags), 32'b0101);
        idle_cycle();

        run_mul(16'h1234, 16'h00AB, 1'b1);
        idle_cycle();

        // Abort a multiply partway through with reset.
        from_bus  = 16'hFFFF;
        Y_shifted = 16'hFFFF;
        alu_op    = 3'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_z", 32'(Z_out), 32'h0);
        checkOutput("abort_flags", 32'(flags), 32'h0);
        idle_cycle();
        applyStimulus(3'd2, 16'hF0F0, 16'h0FF0);
        checkOutput("and_after_abort_z", 32'(Z_out), 32'h00F0);
        idle_cycle();

        // Back-to-back: ADD issued in the MULU done cycle.
        run_mul(16'h00FF, 16'h0102, 1'b0);
        applyStimulus(3'd0, 16'h1111, 16'h2222);
        checkOutput("b2b_z", 32'(Z_out), 32'h3333);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (n % 5 == 0) a = 16'h8000;
            if (op == 3'd7) run_mul(a, b, n[0]);
            else            applyStimulus(op, a, b);
            if (n % 3 != 0) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
